// File: rtl/mul_agent_pkg.sv
// rtl/mul_agent_pkg.sv - shared widths, op encodings and helpers for the multiply/divide agent
package mul_agent_pkg;

  localparam int XLEN       = 32;
  localparam int MULBUF_LEN = 2;
  localparam int TAG_W      = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mul_op_e;

  function automatic logic [31:0] rd_onehot(input logic [TAG_W-1:0] rd);
    logic [31:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mul_agent_if.sv
// rtl/mul_agent_if.sv - issue request, unit launch/retire and writeback channels of the agent
interface mul_req_if;
  import mul_agent_pkg::*;
  logic              req_valid;
  mul_op_e           req_para;
  logic [XLEN-1:0]   req_rs0;
  logic [XLEN-1:0]   req_rs1;
  logic [TAG_W-1:0]  req_rd;
  logic              req_ready;

  modport master (output req_valid, req_para, req_rs0, req_rs1, req_rd, input req_ready);
  modport slave  (input req_valid, req_para, req_rs0, req_rs1, req_rd, output req_ready);
endinterface

interface mul_unit_if;
  import mul_agent_pkg::*;
  logic                       mul_initial;
  mul_op_e                    mul_para;
  logic [XLEN-1:0]            mul_rs0;
  logic [XLEN-1:0]            mul_rs1;
  logic                       mul_ready;
  logic                       mul_finished;
  logic [MULBUF_LEN*XLEN-1:0] mul_data;
  logic                       mul_ack;

  modport master (output mul_initial, mul_para, mul_rs0, mul_rs1, mul_ack,
                  input mul_ready, mul_finished, mul_data);
  modport slave  (input mul_initial, mul_para, mul_rs0, mul_rs1, mul_ack,
                  output mul_ready, mul_finished, mul_data);
endinterface

interface mul_wb_if;
  import mul_agent_pkg::*;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             wb_ready;

  modport master (output wb_valid, wb_rd, wb_data, input wb_ready);
  modport slave  (input wb_valid, wb_rd, wb_data, output wb_ready);
endinterface

// File: rtl/mul_agent_tag_fifo.sv
// rtl/mul_agent_tag_fifo.sv - in-order destination-tag FIFO with flush and flattened entry view
module mul_agent_tag_fifo #(
  parameter int  DEPTH = 4,
  parameter int  W     = 5,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic [DEPTH*W-1:0] entries,
  output logic [DEPTH-1:0]   valid
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  // A pop frees the head slot, so a push is still legal at full in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = bump(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_d = bump(rd_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_comb begin
    int off;
    off = 0;
    for (int i = 0; i < DEPTH; i++) begin
      off = (i >= int'(rd_ptr_q)) ? i - int'(rd_ptr_q) : i + DEPTH - int'(rd_ptr_q);
      valid[i]          = (off < int'(count_q));
      entries[i*W +: W] = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/mul_agent.sv
// rtl/mul_agent.sv - launches MUL/DIV ops into the unit, retires results in order to a registered writeback port
module mul_agent
  import mul_agent_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mul_req_if.slave          req,
  mul_unit_if.master        mu,
  mul_wb_if.master          wb,
  input  logic              clear_pipeline,
  output logic [31:0]       rd_pending
);

  logic                           tag_full, tag_empty;
  logic [TAG_W-1:0]               tag_head;
  logic [TAG_DEPTH*TAG_W-1:0]     tag_entries;
  logic [TAG_DEPTH-1:0]           tag_valid;
  logic [$clog2(TAG_DEPTH+1)-1:0] unused_tag_count;
  logic                           unused_data;
  logic                           accept, pop;
  logic                           wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]               wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]                wb_data_q, wb_data_d;
  logic [31:0]                    pend_all;

  // Only the oldest result word is consumed; deeper words are popped on later cycles.
  assign unused_data = ^mu.mul_data[MULBUF_LEN*XLEN-1:XLEN];

  assign req.req_ready  = rst & mu.mul_ready & ~tag_full & ~clear_pipeline;
  assign accept         = req.req_valid & req.req_ready;
  assign mu.mul_initial = accept;
  assign mu.mul_para    = req.req_para;
  assign mu.mul_rs0     = req.req_rs0;
  assign mu.mul_rs1     = req.req_rs1;

  assign pop        = mu.mul_finished & ~tag_empty & (~wb_valid_q | wb.wb_ready) & ~clear_pipeline;
  assign mu.mul_ack = pop;

  mul_agent_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear_pipeline),
    .push      (accept),
    .push_data (req.req_rd),
    .pop       (pop),
    .head      (tag_head),
    .count     (unused_tag_count),
    .full      (tag_full),
    .empty     (tag_empty),
    .entries   (tag_entries),
    .valid     (tag_valid)
  );

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (clear_pipeline) begin
      wb_valid_d = 1'b0;
    end else if (pop) begin
      wb_rd_d    = tag_head;
      wb_data_d  = mu.mul_data[XLEN-1:0];
      wb_valid_d = (tag_head != '0);
    end else if (wb_valid_q && wb.wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb.wb_valid = wb_valid_q;
  assign wb.wb_rd    = wb_rd_q;
  assign wb.wb_data  = wb_data_q;

  always_comb begin
    pend_all = '0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      if (tag_valid[i]) pend_all = pend_all | rd_onehot(tag_entries[i*TAG_W +: TAG_W]);
    end
    if (wb_valid_q) pend_all = pend_all | rd_onehot(wb_rd_q);
  end

  assign rd_pending = {pend_all[31:1], 1'b0};

  a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst)
    !(mu.mul_finished && tag_empty));

endmodule

// File: tb/tb_mul_agent.sv
// tb/tb_mul_agent.sv - directed bench for mul_agent with a behavioural multiply/divide unit
module tb_mul_agent;
  import mul_agent_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_pipeline = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] rd_pending;
  int          n_tests = 0;
  int          n_fail  = 0;

  mul_req_if  rq ();
  mul_unit_if mu ();
  mul_wb_if   wbi ();

  mul_agent #(.TAG_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (rq),
    .mu             (mu),
    .wb             (wbi),
    .clear_pipeline (clear_pipeline),
    .rd_pending     (rd_pending)
  );

  always #5 clk = ~clk;

  // Unit model: results become available the cycle after launch unless held.
  logic [31:0] um [8];
  logic [2:0]  uh = '0;
  logic [2:0]  ut = '0;
  logic [3:0]  uc = '0;

  function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || clear_pipeline) begin
      uh <= '0;
      ut <= '0;
      uc <= '0;
    end else begin
      if (mu.mul_initial) begin
        um[ut] <= calc(mu.mul_para, mu.mul_rs0, mu.mul_rs1);
        ut     <= ut + 3'd1;
      end
      if (mu.mul_ack) uh <= uh + 3'd1;
      uc <= uc + 4'(mu.mul_initial) - 4'(mu.mul_ack);
    end
  end

  assign mu.mul_finished = (uc != 4'd0) && !hold;
  assign mu.mul_data     = {um[uh + 3'd1], um[uh]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mul_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    rq.req_valid = 1'b1;
    rq.req_para  = op;
    rq.req_rs0   = a;
    rq.req_rs1   = b;
    rq.req_rd    = rd;
    #1;
    chk("issue_mul_initial", 64'(mu.mul_initial), 64'd1);
    chk("issue_mul_para", 64'(mu.mul_para), 64'(op));
    tick();
    rq.req_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
    issue(op, a, b, rd);
    tick();
    chk({tag, "_wb_valid"}, 64'(wbi.wb_valid), 64'd1);
    chk({tag, "_wb_rd"}, 64'(wbi.wb_rd), 64'(rd));
    chk({tag, "_wb_data"}, 64'(wbi.wb_data), 64'(exp));
    tick();
    chk({tag, "_wb_done"}, 64'(wbi.wb_valid), 64'd0);
    chk({tag, "_pending_clear"}, 64'(rd_pending), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rq.req_valid = 1'b0;
    rq.req_para  = OP_MUL;
    rq.req_rs0   = '0;
    rq.req_rs1   = '0;
    rq.req_rd    = '0;
    mu.mul_ready = 1'b1;
    wbi.wb_ready = 1'b1;
    tick();
    tick();
    chk("rst_wb_valid", 64'(wbi.wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(wbi.wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wbi.wb_data), 64'd0);
    chk("rst_mul_ack", 64'(mu.mul_ack), 64'd0);
    chk("rst_mul_initial", 64'(mu.mul_initial), 64'd0);
    chk("rst_rd_pending", 64'(rd_pending), 64'd0);
    rst = 1'b1;
    tick();

    // MUL 3x5 -> x7
    issue(OP_MUL, 32'd3, 32'd5, 5'd7);
    chk("mul_pending_set", 64'(rd_pending), 64'h80);
    chk("mul_ack_pulse", 64'(mu.mul_ack), 64'd1);
    tick();
    chk("mul_wb_valid", 64'(wbi.wb_valid), 64'd1);
    chk("mul_wb_rd", 64'(wbi.wb_rd), 64'd7);
    chk("mul_wb_data", 64'(wbi.wb_data), 64'd15);
    chk("mul_pending_hold", 64'(rd_pending), 64'h80);
    tick();
    chk("mul_wb_done", 64'(wbi.wb_valid), 64'd0);
    chk("mul_pending_clear", 64'(rd_pending), 64'd0);

    run_one("div_by_zero", OP_DIV, 32'd7, 32'd0, 5'd3, 32'hFFFF_FFFF);
    run_one("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF);

    // Fill the tag FIFO while the unit holds its results.
    wbi.wb_ready = 1'b0;
    hold = 1'b1;
    issue(OP_MUL, 32'd1, 32'd1, 5'd10);
    issue(OP_MUL, 32'd2, 32'd3, 5'd11);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd12);
    chk("fill_ready_3", 64'(rq.req_ready), 64'd1);
    issue(OP_REMU, 32'd100, 32'd7, 5'd13);
    chk("fill_ready_4", 64'(rq.req_ready), 64'd0);
    chk("fill_pending", 64'(rd_pending), 64'h3C00);
    chk("fill_no_ack", 64'(mu.mul_ack), 64'd0);
    hold = 1'b0;
    wbi.wb_ready = 1'b1;
    #1;
    chk("drain_ack", 64'(mu.mul_ack), 64'd1);
    tick();
    chk("drain0_rd", 64'(wbi.wb_rd), 64'd10);
    chk("drain0_data", 64'(wbi.wb_data), 64'd1);
    chk("drain0_ready", 64'(rq.req_ready), 64'd1);
    tick();
    chk("drain1_rd", 64'(wbi.wb_rd), 64'd11);
    chk("drain1_data", 64'(wbi.wb_data), 64'd6);
    tick();
    chk("drain2_rd", 64'(wbi.wb_rd), 64'd12);
    chk("drain2_data", 64'(wbi.wb_data), 64'd14);
    tick();
    chk("drain3_rd", 64'(wbi.wb_rd), 64'd13);
    chk("drain3_data", 64'(wbi.wb_data), 64'd2);
    chk("drain3_valid", 64'(wbi.wb_valid), 64'd1);
    tick();
    chk("drain_done", 64'(wbi.wb_valid), 64'd0);
    chk("drain_pending", 64'(rd_pending), 64'd0);

    // Result to x0 is acked and discarded.
    issue(OP_MUL, 32'd6, 32'd7, 5'd0);
    chk("x0_ack", 64'(mu.mul_ack), 64'd1);
    chk("x0_pending", 64'(rd_pending), 64'd0);
    tick();
    chk("x0_no_wb", 64'(wbi.wb_valid), 64'd0);
    chk("x0_ack_once", 64'(mu.mul_ack), 64'd0);
    chk("x0_pending_after", 64'(rd_pending), 64'd0);

    // Flush an in-flight DIVU.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd5);
    chk("clr_pending_before", 64'(rd_pending), 64'h20);
    clear_pipeline = 1'b1;
    #1;
    chk("clr_blocks_ack", 64'(mu.mul_ack), 64'd0);
    chk("clr_blocks_ready", 64'(rq.req_ready), 64'd0);
    tick();
    clear_pipeline = 1'b0;
    #1;
    chk("clr_wb_valid", 64'(wbi.wb_valid), 64'd0);
    chk("clr_pending", 64'(rd_pending), 64'd0);
    chk("clr_no_ack", 64'(mu.mul_ack), 64'd0);
    chk("clr_ready_back", 64'(rq.req_ready), 64'd1);
    run_one("mulhu_after_clr", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'd1);

    // Asynchronous reset with a result parked on wb and another in flight.
    wbi.wb_ready = 1'b0;
    issue(OP_MUL, 32'd5, 32'd5, 5'd6);
    tick();
    hold = 1'b1;
    issue(OP_DIV, 32'd100, 32'd3, 5'd8);
    chk("pre_rst_wb_valid", 64'(wbi.wb_valid), 64'd1);
    chk("pre_rst_wb_data", 64'(wbi.wb_data), 64'd25);
    chk("pre_rst_pending", 64'(rd_pending), 64'h140);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wb_valid", 64'(wbi.wb_valid), 64'd0);
    chk("arst_wb_rd", 64'(wbi.wb_rd), 64'd0);
    chk("arst_wb_data", 64'(wbi.wb_data), 64'd0);
    chk("arst_pending", 64'(rd_pending), 64'd0);
    chk("arst_mul_ack", 64'(mu.mul_ack), 64'd0);
    chk("arst_mul_initial", 64'(mu.mul_initial), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    hold = 1'b0;
    wbi.wb_ready = 1'b1;
    tick();
    run_one("mul_after_rst", OP_MUL, 32'd2, 32'd2, 5'd1, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_agent.md
# mul_agent

Issue-side and retire-side partner of the multiply/divide unit. Accepts MUL/DIV requests from the issue stage, launches them into the unit via the initial/ready handshake, and records each destination register in an in-order tag FIFO. It pops finished results one word per cycle with the ack handshake and presents them on a registered writeback port. It also exports a pending-destination bitmap for hazard checking.

## Interface
- XLEN, 32, data width (from define.v)
- MULBUF_LEN, 2, result-buffer depth of the multiply/divide unit
- TAG_DEPTH, 4, tag FIFO entries; must be ≥ MULBUF_LEN+1
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  issue request
- req_para  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_rs0, req_rs1  in  XLEN  operands
- req_rd  in  5  destination register
- req_ready  out  1  request accepted when req_valid & req_ready
- mul_initial  out  1  launch strobe to unit
- mul_para  out  3  = req_para
- mul_rs0, mul_rs1  out  XLEN  = req_rs0, req_rs1
- mul_ready  in  1  unit can accept
- mul_finished  in  1  unit has at least one result word
- mul_data  in  MULBUF_LEN*XLEN  result words; oldest in bits [XLEN-1:0]
- mul_ack  out  1  pop one word this cycle
- clear_pipeline  in  1  flush; also wired to the unit
- wb_valid  out  1  writeback valid
- wb_rd  out  5  writeback register
- wb_data  out  XLEN  writeback value
- wb_ready  in  1  writeback consumer accepts
- rd_pending  out  32  bit r set while a result for xr is in flight; bit 0 always 0

## Operation
- req_ready = mul_ready & ~tag_full & ~clear_pipeline. mul_initial = req_valid & req_ready.
- On accept, push req_rd into the tag FIFO. The FIFO stays in unit completion order, which is in order.
- Pop condition: pop = mul_finished & tag_nonempty & (~wb_valid | wb_ready) & ~clear_pipeline. mul_ack = pop.
- On pop:
  - the tag head and mul_data[XLEN-1:0] load the wb register;
  - wb_valid is set only if the tag is nonzero;
  - an rd=0 result is acked and discarded, with no wb_valid.
- wb_valid & wb_ready with no pop clears wb_valid.
- mul_finished while the FIFO is empty is a protocol error. It is never acked, and the assertion fires.
- rd_pending = OR of one-hot(tag) over valid FIFO entries, plus the wb register while wb_valid. Bit 0 is masked.
- Push and pop in the same cycle are legal at any occupancy, including full: count is unchanged.
  - Push at full never happens because req_ready is low.
- clear_pipeline:
  - empties the FIFO (pointers and count to 0);
  - clears wb_valid and rd_pending;
  - blocks accept and pop that cycle;
  - wins over any simultaneous push/pop/wb handshake.

## Timing
- Reset (rst low, asynchronous):
  - outputs: wb_valid=0, wb_rd=0, wb_data=0, mul_ack=0, mul_initial=0, rd_pending=0;
  - state: FIFO empty.
  - Reset mid-operation drops all in-flight tags; the unit is reset by the same rst.
- req_ready, mul_initial and mul_ack are combinational.
- wb_* are registered: a result appears on wb one cycle after the pop cycle.
- Throughput: one pop per cycle with wb_ready held high. Back-to-back launches are limited only by mul_ready.
- Direct-path ops: for zero operands or dividend<divisor, mul_finished is high the cycle after launch, so wb_valid is high 2 cycles after accept.
- rd_pending:
  - bit sets the cycle after accept;
  - bit clears the cycle after the wb handshake, or after the pop for rd=0.
  - Duplicate rd in flight stays set until the last entry leaves.

## Structure
- Shared package holds:
  - the op encodings (MUL..REMU);
  - XLEN and MULBUF_LEN (already in define.v);
  - the tag width constant (5).
- One sub-module: tag_fifo. It is a parameterized synchronous FIFO with count, full/empty, flush input, and a flattened entries+valid output for the rd_pending OR-reduction.

## Test plan
- MUL 3×5 to x7, wb_ready=1 -> wb_valid, wb_rd=7, wb_data=15; rd_pending[7] high from accept+1 until after the handshake.
- DIV 7/0 to x3 (direct path) -> wb_data=0xFFFFFFFF, 2 cycles after accept. REM −7/2 to x4 -> 0xFFFFFFFF (−1).
- wb_ready=0, issue 4 ops (TAG_DEPTH 4) -> req_ready drops after the 4th accept. Release wb_ready -> results drain in order, one per cycle, with correct rd.
- MUL to x0, 6×7 -> mul_ack pulses once, no wb_valid, rd_pending stays 0.
- DIVU 0xFFFFFFFF/3 in flight, assert clear_pipeline one cycle -> FIFO empty, wb_valid=0, rd_pending=0; next MULHU 0xFFFFFFFF×2 to x9 -> wb_data=1.
- Drop rst mid-divide -> all outputs 0 immediately. After release, MUL 2×2 to x1 -> wb_data=4.
